// File: rtl/pc_gen_ras_if.sv
// pc_gen_ras_if: groups the fetch-PC generator's control/data signals.
//   slave  modport: seen by the PC generator (inputs in, pc/RAS status out)
//   master modport: seen by the fetch/hazard/cache side driving it
// Signals: start_i, pc_write_i, stall_i, flush_i, flush_pc_i, call_i,
//   call_tgt_i, ret_i (requests); pc_o, ras_count_o, ras_miss_o (status).
interface pc_gen_ras_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    logic                           start_i;
    logic                           pc_write_i;
    logic                           stall_i;
    logic                           flush_i;
    logic [XLEN-1:0]                flush_pc_i;
    logic                           call_i;
    logic [XLEN-1:0]                call_tgt_i;
    logic                           ret_i;
    logic [XLEN-1:0]                pc_o;
    logic [$clog2(RAS_DEPTH):0]     ras_count_o;
    logic                           ras_miss_o;

    modport slave (
        input  start_i, pc_write_i, stall_i, flush_i, flush_pc_i,
               call_i, call_tgt_i, ret_i,
        output pc_o, ras_count_o, ras_miss_o
    );

    modport master (
        output start_i, pc_write_i, stall_i, flush_i, flush_pc_i,
               call_i, call_tgt_i, ret_i,
        input  pc_o, ras_count_o, ras_miss_o
    );
endinterface

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: fetch-PC register with return-address-stack prediction.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    pc_gen_ras_if.slave: run/stall/flush/call/return requests in,
//          registered fetch PC, RAS occupancy and miss pulse out.
// Next PC priority: start low > stall > flush > pc_write gate >
//   ret+call > ret > call > sequential.
module pc_gen_ras #(
    parameter int XLEN      = 32,
    parameter int RESET_VEC = 0,
    parameter int INC       = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pc_gen_ras_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t RESET_PC   = addr_t'(RESET_VEC);
    localparam addr_t INC_A      = addr_t'(INC);
    localparam addr_t ALIGN_MASK = ~addr_t'(INC - 1);

    addr_t            pc_q, pc_d;
    addr_t            ras_q [RAS_DEPTH];
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    count_q, count_d;
    logic             miss_q, miss_d;

    logic             ras_clr;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    addr_t            pc_inc;
    addr_t            top_entry;
    logic             ras_empty;
    logic             ras_full;
    logic [PW-1:0]    top_up;
    logic [PW-1:0]    top_dn;

    assign pc_inc    = pc_q + INC_A;
    assign top_entry = ras_q[top_q];
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == CW'(RAS_DEPTH));
    // top_q indexes the newest entry; the pointer wraps, so a push into a
    // full stack lands on the oldest slot.
    assign top_up    = top_q + PW'(1);
    assign top_dn    = top_q - PW'(1);

    always_comb begin
        pc_d    = pc_q;
        top_d   = top_q;
        count_d = count_q;
        miss_d  = 1'b0;
        ras_clr = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = top_up;

        if (!bus.start_i) begin
            pc_d    = RESET_PC;
            top_d   = '0;
            count_d = '0;
            ras_clr = 1'b1;
        end else if (bus.stall_i) begin
            // everything frozen
        end else if (bus.flush_i) begin
            pc_d = bus.flush_pc_i & ALIGN_MASK;
        end else if (bus.pc_write_i) begin
            if (bus.ret_i && bus.call_i) begin
                if (!ras_empty) begin
                    // return and call in one: swap the top entry in place
                    pc_d   = top_entry;
                    wr_en  = 1'b1;
                    wr_idx = top_q;
                end else begin
                    pc_d    = bus.call_tgt_i;
                    wr_en   = 1'b1;
                    top_d   = top_up;
                    count_d = count_q + CW'(1);
                    miss_d  = 1'b1;
                end
            end else if (bus.ret_i) begin
                if (!ras_empty) begin
                    pc_d    = top_entry;
                    top_d   = top_dn;
                    count_d = count_q - CW'(1);
                end else begin
                    pc_d   = pc_inc;
                    miss_d = 1'b1;
                end
            end else if (bus.call_i) begin
                pc_d  = bus.call_tgt_i;
                wr_en = 1'b1;
                top_d = top_up;
                if (!ras_full) begin
                    count_d = count_q + CW'(1);
                end
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            top_q   <= '0;
            count_q <= '0;
            miss_q  <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            count_q <= count_d;
            miss_q  <= miss_d;
            if (ras_clr) begin
                for (int i = 0; i < RAS_DEPTH; i++) begin
                    ras_q[i] <= '0;
                end
            end else if (wr_en) begin
                ras_q[wr_idx] <= pc_inc;
            end
        end
    end

    assign bus.pc_o        = pc_q;
    assign bus.ras_count_o = count_q;
    assign bus.ras_miss_o  = miss_q;
endmodule
